// File: rtl/series_feeder.sv
// rtl/series_feeder.sv - item FIFO plus run sequencer feeding a float32 series summer
// Issues `count` buffered items one at a time and collects the final sum and sticky flags.
module series_feeder #(
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [31:0]              in_data,
   output logic                     in_ready,
   output logic [$clog2(DEPTH):0]   level,
   input  logic                     start,
   input  logic [CNT_W-1:0]         count,
   output logic                     sum_clear,
   output logic                     sum_request,
   output logic [31:0]              item,
   input  logic                     sum_busy,
   input  logic [2:0]               sum_exception,
   input  logic [31:0]              sum_result,
   output logic                     busy,
   output logic                     done,
   output logic [31:0]              result,
   output logic [2:0]               exception,
   output logic                     timeout
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]    FULL_LVL = (AW + 1)'(DEPTH);
   localparam logic [TW-1:0]  T_MAX    = TW'(TIMEOUT);
   localparam logic [TW-1:0]  T_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_SETTLE,
      S_WAIT,
      S_FINISH
   } state_t;

   state_t state, state_d;

   logic [31:0]      mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             push, pop, fifo_empty;
   logic [CNT_W-1:0] remaining;
   logic [TW-1:0]    tcnt;

   assign in_ready   = (level != FULL_LVL);
   assign fifo_empty = (level == '0);
   assign push       = in_valid && in_ready;
   assign pop        = (state == S_ISSUE);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_d;
   end

   always_comb begin
      state_d   = state;
      sum_clear = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               sum_clear = 1'b1;
               state_d   = (count == '0) ? S_FINISH : S_FETCH;
            end
         end
         S_FETCH:  if (!fifo_empty) state_d = S_ISSUE;
         S_ISSUE:  state_d = S_SETTLE;
         S_SETTLE: state_d = S_WAIT;
         S_WAIT: begin
            if (!sum_busy)
               state_d = (remaining == CNT_W'(1)) ? S_FINISH : S_FETCH;
            else if (tcnt >= T_LAST)
               state_d = S_FINISH;
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   assign sum_request = (state == S_ISSUE);
   assign done        = (state == S_FINISH);
   assign busy        = (state != S_IDLE);

   // result is loaded on entry to FINISH so it is already valid while done is high
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         remaining <= '0;
         tcnt      <= '0;
         item      <= '0;
         result    <= '0;
         exception <= '0;
         timeout   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  remaining <= count;
                  exception <= '0;
                  timeout   <= 1'b0;
                  if (count == '0) result <= '0;
               end
            end
            S_FETCH: if (!fifo_empty) item <= mem[rd_ptr];
            S_ISSUE: tcnt <= '0;
            S_WAIT: begin
               if (!sum_busy) begin
                  exception <= exception | sum_exception;
                  remaining <= remaining - 1'b1;
                  if (remaining == CNT_W'(1)) result <= sum_result;
               end else begin
                  if (tcnt != T_MAX) tcnt <= tcnt + 1'b1;
                  if (tcnt >= T_LAST) begin
                     timeout <= 1'b1;
                     result  <= sum_result;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_series_feeder.sv
// tb/tb_series_feeder.sv - self-checking bench for series_feeder
// Vector table, hand sequences and random runs against a queue-based reference model.
module tb_series_feeder;
   localparam int DEPTH   = 8;
   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 64;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic [31:0]      in_data = '0;
   logic             in_ready;
   logic [3:0]       level;
   logic             start = 1'b0;
   logic [CNT_W-1:0] count = '0;
   logic             sum_clear, sum_request;
   logic [31:0]      item;
   logic             sum_busy;
   logic [2:0]       sum_exception;
   logic [31:0]      sum_result;
   logic             busy, done, timeout;
   logic [31:0]      result;
   logic [2:0]       exception;

   series_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .level(level), .start(start), .count(count), .sum_clear(sum_clear),
      .sum_request(sum_request), .item(item), .sum_busy(sum_busy),
      .sum_exception(sum_exception), .sum_result(sum_result), .busy(busy), .done(done),
      .result(result), .exception(exception), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // summer model: integer accumulate of items, programmable busy time and flags
   logic [31:0] acc;
   int          busy_cnt;
   logic [2:0]  exc_reg;
   int          s_idx;
   int          busy_len = 2;
   logic        hold_busy = 1'b0;
   logic        use_fixed = 1'b0;
   logic [31:0] fixed_res = '0;
   logic [2:0]  exc_plan [16];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0; busy_cnt <= 0; exc_reg <= '0; s_idx <= 0;
      end else begin
         if (sum_clear) begin
            acc <= '0; s_idx <= 0;
         end
         if (sum_request) begin
            acc      <= acc + item;
            busy_cnt <= busy_len;
            exc_reg  <= exc_plan[s_idx % 16];
            s_idx    <= s_idx + 1;
         end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
         end
      end
   end

   assign sum_busy      = hold_busy || (busy_cnt != 0);
   assign sum_result    = use_fixed ? fixed_res : acc;
   assign sum_exception = exc_reg;

   int          cyc = 0;
   int          n_done = 0, n_clr = 0;
   int          req_cyc = 0, done_cyc = 0, clr_cyc = 0;
   logic [31:0] req_log [$];

   always @(negedge clk) begin
      cyc++;
      if (sum_request) begin req_log.push_back(item); req_cyc = cyc; end
      if (sum_clear)   begin n_clr++; clr_cyc = cyc; end
      if (done)        begin n_done++; done_cyc = cyc; end
   end

   logic [31:0] model_q [$];

   typedef struct {
      int         n_push;
      int         cnt;
      int         blen;
      logic [2:0] e0;
      logic [2:0] e1;
      int         exp_level;
      logic [2:0] exp_exc;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc1();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_plan();
      for (int i = 0; i < 16; i++) exc_plan[i] = 3'b000;
   endtask

   task automatic push_item(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      cyc1();
      in_valid = 1'b0;
      model_q.push_back(d);
   endtask

   task automatic wait_done(input string name, input int d0, input int limit);
      int k;
      k = 0;
      while (n_done == d0 && k < limit) begin
         @(negedge clk);
         #1;
         k++;
      end
      checks++;
      if (n_done == d0) begin
         errors++;
         $display("FAIL %s_done_wait: no done within %0d cycles", name, limit);
      end
   endtask

   task automatic finish_check(input string name, input int c, input int r0, input int d0,
                               input int cl0, input logic [2:0] exp_exc, input int exp_level,
                               input logic exp_to);
      logic [31:0] e, exp_sum;
      exp_sum = '0;
      check({name, "_nreq"}, req_log.size() - r0, c);
      for (int i = 0; i < c; i++) begin
         e = '0;
         if (model_q.size() > 0) e = model_q.pop_front();
         exp_sum = exp_sum + e;
         if (r0 + i < req_log.size()) check({name, "_item"}, req_log[r0 + i], e);
      end
      if (c == 0) exp_sum = '0;
      else if (use_fixed) exp_sum = fixed_res;
      check({name, "_done"}, done, 1'b1);
      check({name, "_result"}, result, exp_sum);
      check({name, "_exception"}, exception, exp_exc);
      check({name, "_timeout"}, timeout, exp_to);
      check({name, "_clears"}, n_clr - cl0, 1);
      check({name, "_level"}, level, exp_level);
      repeat (2) cyc1();
      check({name, "_busy_after"}, busy, 1'b0);
      check({name, "_done_count"}, n_done - d0, 1);
      check({name, "_result_hold"}, result, exp_sum);
   endtask

   task automatic run_check(input string name, input int c, input logic [2:0] exp_exc,
                            input int exp_level);
      int r0, d0, cl0;
      r0 = req_log.size(); d0 = n_done; cl0 = n_clr;
      start = 1'b1;
      count = CNT_W'(c);
      cyc1();
      start = 1'b0;
      wait_done(name, d0, 2000);
      finish_check(name, c, r0, d0, cl0, exp_exc, exp_level, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs [5];
      int r0, d0, cl0, k, lvl, n_push, c;
      logic [2:0] ex;

      vecs[0] = '{3, 3, 2, 3'd0, 3'd0, 0, 3'd0};
      vecs[1] = '{4, 2, 0, 3'd1, 3'd2, 2, 3'd3};
      vecs[2] = '{1, 3, 5, 3'd4, 3'd0, 0, 3'd4};
      vecs[3] = '{8, 1, 1, 3'd2, 3'd7, 7, 3'd2};
      vecs[4] = '{1, 8, 3, 3'd0, 3'd4, 0, 3'd4};

      clear_plan();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      cyc1();

      check("rst_level", level, 0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_req", sum_request, 1'b0);
      check("rst_item", item, 0);
      check("rst_result", result, 0);
      check("rst_exception", exception, 0);
      check("rst_timeout", timeout, 1'b0);

      // basic run with a summer that reports a fixed final sum
      busy_len = 2; use_fixed = 1'b1; fixed_res = 32'h40C00000;
      push_item(32'h3F800000);
      push_item(32'h40000000);
      push_item(32'h40400000);
      run_check("basic", 3, 3'b000, 0);
      use_fixed = 1'b0;

      for (int v = 0; v < 5; v++) begin
         busy_len = vecs[v].blen;
         clear_plan();
         exc_plan[0] = vecs[v].e0;
         exc_plan[1] = vecs[v].e1;
         for (int i = 0; i < vecs[v].n_push; i++) push_item($urandom);
         run_check($sformatf("vec%0d", v), vecs[v].cnt, vecs[v].exp_exc, vecs[v].exp_level);
      end

      for (int it = 0; it < 12; it++) begin
         lvl    = model_q.size();
         n_push = $urandom_range(DEPTH - lvl, 0);
         for (int i = 0; i < n_push; i++) push_item($urandom);
         c  = $urandom_range(model_q.size(), 0);
         busy_len = $urandom_range(6, 0);
         clear_plan();
         ex = 3'b000;
         for (int i = 0; i < c; i++) begin
            exc_plan[i] = 3'($urandom_range(7, 0));
            ex = ex | exc_plan[i];
         end
         run_check($sformatf("rand%0d", it), c, ex, model_q.size() - c);
      end
      clear_plan();
      if (model_q.size() > 0) run_check("rand_drain", model_q.size(), 3'b000, 0);

      // fill past capacity, then pop while a push is pending
      busy_len = 0;
      in_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_data = 32'hA000_0000 + 32'(i);
         cyc1();
         if (i < DEPTH) model_q.push_back(in_data);
      end
      check("full_level", level, 8);
      check("full_in_ready", in_ready, 1'b0);
      in_data = 32'hB000_0000;
      r0 = req_log.size(); d0 = n_done; cl0 = n_clr;
      start = 1'b1; count = 16'd1;
      cyc1();
      start = 1'b0;
      k = 0;
      while (!sum_request && k < 20) begin @(negedge clk); k++; end
      check("full_issue_seen", sum_request, 1'b1);
      check("full_pop_cycle_ready", in_ready, 1'b0);
      check("full_pop_cycle_level", level, 8);
      @(negedge clk);
      check("full_after_pop_ready", in_ready, 1'b1);
      check("full_after_pop_level", level, 7);
      @(posedge clk);
      #1 in_valid = 1'b0;
      model_q.push_back(32'hB000_0000);
      check("full_refill_level", level, 8);
      wait_done("full_pop", d0, 200);
      finish_check("full_pop", 1, r0, d0, cl0, 3'b000, 8, 1'b0);
      run_check("full_drain", 8, 3'b000, 0);

      // empty FIFO stall in FETCH
      busy_len = 2;
      push_item(32'h1111_0001);
      r0 = req_log.size(); d0 = n_done; cl0 = n_clr;
      start = 1'b1; count = 16'd2;
      cyc1();
      start = 1'b0;
      repeat (20) cyc1();
      check("stall_busy", busy, 1'b1);
      check("stall_no_done", n_done - d0, 0);
      check("stall_nreq", req_log.size() - r0, 1);
      push_item(32'h2222_0002);
      wait_done("stall", d0, 200);
      finish_check("stall", 2, r0, d0, cl0, 3'b000, 0, 1'b0);

      clear_plan();
      exc_plan[0] = 3'b001;
      exc_plan[1] = 3'b100;
      push_item(32'h0000_0005);
      push_item(32'h0000_0007);
      run_check("sticky", 2, 3'b101, 0);
      clear_plan();
      run_check("sticky_clear", 0, 3'b000, 0);

      use_fixed = 1'b1; fixed_res = 32'hDEADBEEF;
      run_check("count0", 0, 3'b000, 0);
      check("count0_latency", done_cyc - clr_cyc, 1);
      use_fixed = 1'b0;

      // summer stuck busy: abort after TIMEOUT cycles in WAIT
      push_item(32'h3F800000);
      hold_busy = 1'b1;
      r0 = req_log.size(); d0 = n_done; cl0 = n_clr;
      start = 1'b1; count = 16'd1;
      cyc1();
      start = 1'b0;
      wait_done("timeout", d0, 200);
      check("timeout_latency", done_cyc - req_cyc, TIMEOUT + 2);
      finish_check("timeout", 1, r0, d0, cl0, 3'b000, 0, 1'b1);
      hold_busy = 1'b0;
      repeat (3) cyc1();
      check("timeout_held", timeout, 1'b1);

      // reset asserted while waiting on the summer
      push_item(32'h40400000);
      push_item(32'h40800000);
      hold_busy = 1'b1;
      d0 = n_done;
      start = 1'b1; count = 16'd2;
      cyc1();
      start = 1'b0;
      k = 0;
      while (!sum_request && k < 20) begin @(negedge clk); k++; end
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_level", level, 0);
      check("midrst_in_ready", in_ready, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_req", sum_request, 1'b0);
      check("midrst_clear", sum_clear, 1'b0);
      check("midrst_item", item, 0);
      check("midrst_result", result, 0);
      check("midrst_exception", exception, 0);
      check("midrst_timeout", timeout, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      hold_busy = 1'b0;
      model_q.delete();
      repeat (10) cyc1();
      check("midrst_no_done", n_done - d0, 0);
      check("midrst_level_after", level, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
